// File: rtl/vex_int_unit.sv
// Vector integer execution stage: one-cycle element-wise integer ALU plus a
// cross-µop reduction accumulator that is folded down to element 0 before writeback.
module vex_int_unit #(
  parameter int VECTOR_REGISTERS = 32,
  parameter int VECTOR_LANES     = 8,
  parameter int DATA_WIDTH       = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 valid_i,
  input  logic [VECTOR_LANES-1:0]              lane_valid_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   data1_i,
  input  logic [VECTOR_LANES*DATA_WIDTH-1:0]   data2_i,
  input  logic [VECTOR_LANES-1:0]              mask_i,
  input  logic [5:0]                           funct6_i,
  input  logic [2:0]                           funct3_i,
  input  logic [$clog2(VECTOR_REGISTERS)-1:0]  dst_i,
  input  logic                                 head_uop_i,
  input  logic                                 end_uop_i,
  input  logic                                 is_rdc_i,
  output logic                                 ready_o,
  output logic [VECTOR_LANES-1:0]              wr_en_o,
  output logic [$clog2(VECTOR_REGISTERS)-1:0]  wr_addr_o,
  output logic [VECTOR_LANES*DATA_WIDTH-1:0]   wr_data_o,
  output logic                                 busy_o,
  output logic                                 err_o
);
  localparam int LW = $clog2(VECTOR_LANES);
  localparam int AW = $clog2(VECTOR_REGISTERS);
  localparam int DW = DATA_WIDTH;
  localparam logic [LW-1:0] LAST_CNT = LW'(LW - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FOLD, S_FINAL} state_t;

  state_t                         state_reg, state_next;
  logic [LW-1:0]                  cnt_reg;
  logic [2:0]                     op_reg;
  logic [DW-1:0]                  seed_reg;
  logic [AW-1:0]                  dst_reg;
  logic [VECTOR_LANES-1:0]        wr_en_reg;
  logic [AW-1:0]                  wr_addr_reg;
  logic [VECTOR_LANES*DW-1:0]     wr_data_reg;
  logic                           err_reg;
  logic [VECTOR_LANES*DW-1:0]     acc_flat;
  logic [VECTOR_LANES*DW-1:0]     elem_res;
  logic [LW:0]                    fold_half;

  logic accept, elem_ok, rdc_ok, bad_enc, seq_err;
  logic start_rdc, acc_step, abort_rdc, elem_wb;

  function automatic logic [DW-1:0] elem_op(input logic [5:0] f6, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (f6)
      6'b000000: r = a + b;
      6'b000010: r = a - b;
      6'b000100: r = (a < b) ? a : b;
      6'b000101: r = ($signed(a) < $signed(b)) ? a : b;
      6'b000110: r = (a > b) ? a : b;
      6'b000111: r = ($signed(a) > $signed(b)) ? a : b;
      6'b001001: r = a & b;
      6'b001010: r = a | b;
      6'b001011: r = a ^ b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] rdc_op(input logic [2:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [DW-1:0] r;
    case (op)
      3'd0:    r = a + b;
      3'd1:    r = a & b;
      3'd2:    r = a | b;
      3'd3:    r = a ^ b;
      3'd4:    r = (a < b) ? a : b;
      3'd5:    r = ($signed(a) < $signed(b)) ? a : b;
      3'd6:    r = (a > b) ? a : b;
      default: r = ($signed(a) > $signed(b)) ? a : b;
    endcase
    return r;
  endfunction

  // Identity element so that invalid lanes of the head µop never influence the result.
  function automatic logic [DW-1:0] rdc_identity(input logic [2:0] op);
    logic [DW-1:0] r;
    case (op)
      3'd1, 3'd4: r = '1;
      3'd5:       r = {1'b0, {(DW-1){1'b1}}};
      3'd7:       r = {1'b1, {(DW-1){1'b0}}};
      default:    r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    accept    = valid_i & ready_o;
    elem_ok   = !is_rdc_i && (funct3_i inside {3'b000, 3'b011, 3'b100}) &&
                (funct6_i inside {6'b000000, 6'b000010, 6'b000100, 6'b000101, 6'b000110,
                                  6'b000111, 6'b001001, 6'b001010, 6'b001011});
    rdc_ok    = is_rdc_i && (funct3_i == 3'b010) && (funct6_i[5:3] == 3'b000);
    bad_enc   = !(elem_ok || rdc_ok);
    seq_err   = ((state_reg == S_IDLE) && is_rdc_i && !head_uop_i) ||
                ((state_reg == S_ACC) && (!is_rdc_i || head_uop_i || bad_enc));
    start_rdc = accept && (state_reg == S_IDLE) && rdc_ok && head_uop_i;
    acc_step  = accept && (state_reg == S_ACC) && rdc_ok && !head_uop_i;
    abort_rdc = accept && (state_reg == S_ACC) && (!is_rdc_i || head_uop_i || bad_enc);
    elem_wb   = accept && (!is_rdc_i || bad_enc);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_reg <= S_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_rdc) state_next = end_uop_i ? S_FOLD : S_ACC;
      S_ACC: begin
        if (abort_rdc)                    state_next = S_IDLE;
        else if (acc_step && end_uop_i)   state_next = S_FOLD;
      end
      S_FOLD:  if (cnt_reg == LAST_CNT) state_next = S_FINAL;
      S_FINAL: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_reg == S_IDLE) || (state_reg == S_ACC);
    busy_o  = (state_reg != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_reg  <= '0;
      op_reg   <= '0;
      seed_reg <= '0;
      dst_reg  <= '0;
    end else begin
      if (start_rdc) begin
        seed_reg <= data1_i[DW-1:0];
        op_reg   <= funct6_i[2:0];
        dst_reg  <= dst_i;
      end
      cnt_reg <= (state_reg == S_FOLD) ? cnt_reg + 1'b1 : '0;
    end
  end

  // Each fold step halves the live region: lane k absorbs lane k+half.
  assign fold_half = (LW+1)'(VECTOR_LANES) >> (cnt_reg + 1'b1);

  for (genvar gi = 0; gi < VECTOR_LANES; gi++) begin : g_lane
    logic [DW-1:0] vs1, vs2, acc_reg;
    logic [LW-1:0] partner;
    logic          fold_en;

    assign vs1     = data1_i[gi*DW +: DW];
    assign vs2     = data2_i[gi*DW +: DW];
    assign partner = LW'(gi) + fold_half[LW-1:0];
    assign fold_en = (state_reg == S_FOLD) && ((LW+1)'(gi) < fold_half);
    assign acc_flat[gi*DW +: DW] = acc_reg;
    assign elem_res[gi*DW +: DW] = bad_enc ? '0 : elem_op(funct6_i, vs2, vs1);

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
        acc_reg <= '0;
      else if (start_rdc)
        acc_reg <= lane_valid_i[gi] ? vs2 : rdc_identity(funct6_i[2:0]);
      else if (acc_step && lane_valid_i[gi])
        acc_reg <= rdc_op(op_reg, acc_reg, vs2);
      else if (fold_en)
        acc_reg <= rdc_op(op_reg, acc_reg, acc_flat[partner*DW +: DW]);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_en_reg   <= '0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= accept && (bad_enc || seq_err);
      if (elem_wb) begin
        wr_en_reg   <= lane_valid_i & mask_i;
        wr_addr_reg <= dst_i;
        wr_data_reg <= elem_res;
      end else if (state_reg == S_FINAL) begin
        wr_en_reg   <= VECTOR_LANES'(1);
        wr_addr_reg <= dst_reg;
        wr_data_reg <= (VECTOR_LANES*DW)'(rdc_op(op_reg, seed_reg, acc_flat[DW-1:0]));
      end else begin
        wr_en_reg <= '0;
      end
    end
  end

  assign wr_en_o   = wr_en_reg;
  assign wr_addr_o = wr_addr_reg;
  assign wr_data_o = wr_data_reg;
  assign err_o     = err_reg;
endmodule

// File: tb/tb_vex_int_unit.sv
// Bench for vex_int_unit: directed scenarios plus randomized element-wise and
// reduction µops checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_vex_int_unit;
  localparam int L  = 8;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int WB = L*DW;
  localparam logic [2:0] OPIVV = 3'b000, OPMVV = 3'b010, OPIVI = 3'b011, OPIVX = 3'b100;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          valid_i;
  logic [L-1:0]  lane_valid_i, mask_i;
  logic [WB-1:0] data1_i, data2_i;
  logic [5:0]    funct6_i;
  logic [2:0]    funct3_i;
  logic [AW-1:0] dst_i;
  logic          head_uop_i, end_uop_i, is_rdc_i;
  logic          ready_o, busy_o, err_o;
  logic [L-1:0]  wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [WB-1:0] wr_data_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] d1 [L];
  logic [DW-1:0] d2 [L];
  logic [DW-1:0] rdc_q [$];
  logic [5:0]    f6_list [9] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd6, 6'd7, 6'd9, 6'd10, 6'd11};
  logic [2:0]    f3_list [3] = '{OPIVV, OPIVI, OPIVX};

  vex_int_unit #(.VECTOR_REGISTERS(32), .VECTOR_LANES(L), .DATA_WIDTH(DW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .valid_i(valid_i), .lane_valid_i(lane_valid_i),
    .data1_i(data1_i), .data2_i(data2_i), .mask_i(mask_i), .funct6_i(funct6_i),
    .funct3_i(funct3_i), .dst_i(dst_i), .head_uop_i(head_uop_i), .end_uop_i(end_uop_i),
    .is_rdc_i(is_rdc_i), .ready_o(ready_o), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_uop(input logic [5:0] f6, input logic [2:0] f3, input logic [AW-1:0] dst,
                         input logic head, input logic last, input logic rdc,
                         input logic [L-1:0] lv, input logic [L-1:0] mk);
    valid_i = 1'b1; funct6_i = f6; funct3_i = f3; dst_i = dst;
    head_uop_i = head; end_uop_i = last; is_rdc_i = rdc; lane_valid_i = lv; mask_i = mk;
    for (int k = 0; k < L; k++) begin
      data1_i[k*DW +: DW] = d1[k];
      data2_i[k*DW +: DW] = d2[k];
    end
    $display("uop f6=%b f3=%b rdc=%0b head=%0b end=%0b dst=%0d valid=%b mask=%b",
             f6, f3, rdc, head, last, dst, lv, mk);
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < L; k++) begin
      d1[k] = $urandom;
      d2[k] = $urandom;
    end
  endtask

  // Reference: result = vs2 op vs1 computed with wide integer arithmetic.
  function automatic logic [DW-1:0] ref_elem(input logic [5:0] f6, input logic [DW-1:0] vs2,
                                             input logic [DW-1:0] vs1);
    longint unsigned u2, u1;
    int s2, s1;
    u2 = 64'(vs2); u1 = 64'(vs1); s2 = int'(vs2); s1 = int'(vs1);
    case (f6)
      6'd0:    return DW'(u2 + u1);
      6'd2:    return DW'(u2 - u1);
      6'd4:    return (u2 <= u1) ? vs2 : vs1;
      6'd5:    return (s2 <= s1) ? vs2 : vs1;
      6'd6:    return (u2 >= u1) ? vs2 : vs1;
      6'd7:    return (s2 >= s1) ? vs2 : vs1;
      6'd9:    return vs2 & vs1;
      6'd10:   return vs2 | vs1;
      6'd11:   return vs2 ^ vs1;
      default: return '0;
    endcase
  endfunction

  function automatic logic [WB-1:0] ref_vec(input logic [5:0] f6);
    logic [WB-1:0] r;
    for (int k = 0; k < L; k++) r[k*DW +: DW] = ref_elem(f6, d2[k], d1[k]);
    return r;
  endfunction

  function automatic logic [DW-1:0] combine(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    longint unsigned ua, ub;
    int sa, sb;
    ua = 64'(a); ub = 64'(b); sa = int'(a); sb = int'(b);
    case (op)
      3'd0:    return DW'(ua + ub);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return (ua < ub) ? a : b;
      3'd5:    return (sa < sb) ? a : b;
      3'd6:    return (ua > ub) ? a : b;
      default: return (sa > sb) ? a : b;
    endcase
  endfunction

  // Sequential left fold over every valid element seen, starting from the seed.
  function automatic logic [DW-1:0] ref_reduce(input logic [2:0] op, input logic [DW-1:0] seed);
    logic [DW-1:0] r;
    r = seed;
    foreach (rdc_q[i]) r = combine(op, r, rdc_q[i]);
    return r;
  endfunction

  task automatic push_valid(input logic [L-1:0] lv);
    for (int k = 0; k < L; k++) if (lv[k]) rdc_q.push_back(d2[k]);
  endtask

  // Called right after the end µop has been accepted.
  task automatic rdc_tail(input string tag, input logic [DW-1:0] exp_v, input logic [AW-1:0] exp_dst);
    idle();
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_ready_low"}, WB'(ready_o), WB'(1'b0));
      chk({tag, "_no_wr"}, WB'(wr_en_o), WB'(0));
      tick();
    end
    chk({tag, "_en"}, WB'(wr_en_o), WB'(8'h01));
    chk({tag, "_data"}, wr_data_o, WB'(exp_v));
    chk({tag, "_addr"}, WB'(wr_addr_o), WB'(exp_dst));
    chk({tag, "_busy"}, WB'(busy_o), WB'(1'b0));
    $display("rdc %s lane0=%0h", tag, wr_data_o[DW-1:0]);
  endtask

  initial begin
    logic [L-1:0]  lv, mk;
    logic [AW-1:0] dst;
    logic [5:0]    f6;
    logic [2:0]    op;
    logic [WB-1:0] exp_data;
    logic [DW-1:0] seed;
    int            n;

    valid_i = 1'b0; lane_valid_i = '0; mask_i = '0; data1_i = '0; data2_i = '0;
    funct6_i = '0; funct3_i = '0; dst_i = '0; head_uop_i = 1'b0; end_uop_i = 1'b0; is_rdc_i = 1'b0;
    rstn_i = 1'b0;
    repeat (2) tick();
    chk("rst_ready", WB'(ready_o), WB'(1'b1));
    chk("rst_busy", WB'(busy_o), WB'(1'b0));
    chk("rst_en", WB'(wr_en_o), WB'(0));
    chk("rst_err", WB'(err_o), WB'(1'b0));
    chk("rst_data", wr_data_o, WB'(0));
    rstn_i = 1'b1;
    tick();

    // vadd.vv: lane k = (100+k) + k
    for (int k = 0; k < L; k++) begin d1[k] = DW'(k); d2[k] = DW'(100 + k); end
    set_uop(6'd0, OPIVV, 5'd7, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    tick();
    for (int k = 0; k < L; k++) exp_data[k*DW +: DW] = DW'(100 + 2*k);
    chk("vadd_en", WB'(wr_en_o), WB'(8'hFF));
    chk("vadd_data", wr_data_o, exp_data);
    chk("vadd_addr", WB'(wr_addr_o), WB'(5'd7));
    chk("vadd_err", WB'(err_o), WB'(1'b0));
    idle();
    tick();
    chk("idle_en", WB'(wr_en_o), WB'(0));
    chk("idle_hold_data", wr_data_o, exp_data);
    chk("idle_hold_addr", WB'(wr_addr_o), WB'(5'd7));

    // vsub.vx: 3 - 5 wraps
    for (int k = 0; k < L; k++) begin d1[k] = 32'd5; d2[k] = 32'd3; end
    set_uop(6'd2, OPIVX, 5'd3, 1'b0, 1'b0, 1'b0, 8'h1F, 8'hFF);
    tick();
    chk("vsub_en", WB'(wr_en_o), WB'(8'h1F));
    chk("vsub_data", wr_data_o, {L{32'hFFFF_FFFE}});

    // Three back-to-back vxor µops
    for (int i = 0; i < 3; i++) begin
      randomize_ops();
      lv = 8'($urandom);
      set_uop(6'd11, OPIVV, AW'(10 + i), 1'b0, 1'b0, 1'b0, lv, 8'hFF);
      tick();
      chk("vxor_en", WB'(wr_en_o), WB'(lv));
      chk("vxor_data", wr_data_o, ref_vec(6'd11));
      chk("vxor_addr", WB'(wr_addr_o), WB'(AW'(10 + i)));
    end
    idle();

    // Randomized element-wise ops, with occasional idle cycles
    for (int i = 0; i < 24; i++) begin
      randomize_ops();
      f6 = f6_list[$urandom_range(8)];
      lv = 8'($urandom); mk = 8'($urandom); dst = AW'($urandom);
      set_uop(f6, f3_list[$urandom_range(2)], dst, 1'b0, 1'b0, 1'b0, lv, mk);
      tick();
      exp_data = ref_vec(f6);
      chk("rand_en", WB'(wr_en_o), WB'(lv & mk));
      chk("rand_data", wr_data_o, exp_data);
      chk("rand_addr", WB'(wr_addr_o), WB'(dst));
      chk("rand_err", WB'(err_o), WB'(1'b0));
      if ($urandom_range(3) == 0) begin
        idle();
        tick();
        chk("rand_idle_en", WB'(wr_en_o), WB'(0));
        chk("rand_idle_hold", wr_data_o, exp_data);
      end
    end
    idle();
    tick();

    // vredsum over two µops: 10 + sum(1..16) = 146
    for (int k = 0; k < L; k++) begin d1[k] = 32'd10; d2[k] = DW'(k + 1); end
    set_uop(6'd0, OPMVV, 5'd12, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    tick();
    chk("redsum_head_busy", WB'(busy_o), WB'(1'b1));
    chk("redsum_head_ready", WB'(ready_o), WB'(1'b1));
    chk("redsum_head_no_wr", WB'(wr_en_o), WB'(0));
    for (int k = 0; k < L; k++) d2[k] = DW'(k + 9);
    set_uop(6'd0, OPMVV, 5'd12, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    rdc_tail("redsum", 32'd146, 5'd12);

    // vredmin single µop, invalid lanes carry values that must be ignored
    for (int k = 0; k < L; k++) begin d1[k] = 32'd0; d2[k] = -32'sd1000; end
    d2[0] = -32'sd3; d2[1] = 32'd7; d2[2] = 32'd100;
    set_uop(6'd5, OPMVV, 5'd20, 1'b1, 1'b1, 1'b1, 8'h07, 8'hFF);
    tick();
    rdc_tail("redmin", 32'hFFFF_FFFD, 5'd20);

    // Randomized reductions of 1..3 µops
    for (int r = 0; r < 8; r++) begin
      op = 3'($urandom_range(7)); n = $urandom_range(1, 3); dst = AW'($urandom);
      rdc_q.delete();
      seed = $urandom;
      for (int u = 0; u < n; u++) begin
        randomize_ops();
        if (u == 0) d1[0] = seed;
        lv = 8'($urandom);
        push_valid(lv);
        set_uop({3'b000, op}, OPMVV, dst, u == 0, u == n - 1, 1'b1, lv, 8'($urandom));
        tick();
        if (u != n - 1) begin
          chk("rrdc_acc_busy", WB'(busy_o), WB'(1'b1));
          chk("rrdc_acc_no_wr", WB'(wr_en_o), WB'(0));
        end
      end
      rdc_tail("rrdc", ref_reduce(op, seed), dst);
    end

    // Unsupported funct6 on OPIVV: zero data on valid lanes, err pulse
    randomize_ops();
    lv = 8'b1011_0110;
    set_uop(6'b111111, OPIVV, 5'd9, 1'b0, 1'b0, 1'b0, lv, 8'hFF);
    tick();
    chk("bad_en", WB'(wr_en_o), WB'(lv));
    chk("bad_data", wr_data_o, WB'(0));
    chk("bad_err", WB'(err_o), WB'(1'b1));
    idle();
    tick();
    chk("bad_err_pulse", WB'(err_o), WB'(1'b0));

    // Reduction µop without head while idle
    set_uop(6'd0, OPMVV, 5'd4, 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    chk("nohead_err", WB'(err_o), WB'(1'b1));
    chk("nohead_busy", WB'(busy_o), WB'(1'b0));
    idle();
    tick();
    chk("nohead_err_pulse", WB'(err_o), WB'(1'b0));

    // Element-wise µop inside a reduction: executed, flagged, reduction dropped
    randomize_ops();
    set_uop(6'd0, OPMVV, 5'd5, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
    tick();
    randomize_ops();
    lv = 8'($urandom);
    set_uop(6'd0, OPIVV, 5'd6, 1'b0, 1'b0, 1'b0, lv, 8'hFF);
    tick();
    chk("abort_err", WB'(err_o), WB'(1'b1));
    chk("abort_en", WB'(wr_en_o), WB'(lv));
    chk("abort_data", wr_data_o, ref_vec(6'd0));
    chk("abort_busy", WB'(busy_o), WB'(1'b0));
    idle();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("abort_no_wr", WB'(wr_en_o), WB'(0));
    end

    // Reset during FOLD discards the reduction
    for (int k = 0; k < L; k++) begin d1[k] = 32'd1; d2[k] = DW'(k + 1); end
    set_uop(6'd0, OPIVV, 5'd17, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    tick();
    set_uop(6'd0, OPMVV, 5'd18, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    tick();
    idle();
    tick();
    chk("fold_busy", WB'(busy_o), WB'(1'b1));
    rstn_i = 1'b0;
    #1;
    chk("midrst_ready", WB'(ready_o), WB'(1'b1));
    chk("midrst_busy", WB'(busy_o), WB'(1'b0));
    chk("midrst_en", WB'(wr_en_o), WB'(0));
    chk("midrst_addr", WB'(wr_addr_o), WB'(0));
    chk("midrst_data", wr_data_o, WB'(0));
    chk("midrst_err", WB'(err_o), WB'(1'b0));
    #2;
    rstn_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("postrst_no_wr", WB'(wr_en_o), WB'(0));
      chk("postrst_ready", WB'(ready_o), WB'(1'b1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
